// File: rtl/stim_sequencer.sv
// stim_sequencer: walks every WIDTH-bit input pattern, holds each one for DWELL
// cycles and records the 1-bit DUT response into a truth table.
// Optional build macro SEQ_GRAY_EN: present patterns in Gray-code order
// (pattern = idx ^ (idx >> 1)). The truth table stays indexed by pattern value.
module stim_sequencer #(
    parameter int WIDTH = 3,
    parameter int DWELL = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    dir,
    input  logic                    y,
    output logic [WIDTH-1:0]        pattern,
    output logic                    busy,
    output logic                    done,
    output logic [(1<<WIDTH)-1:0]   truth_table,
    output logic                    table_valid
);

    localparam logic [WIDTH-1:0] IDX_MAX    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] IDX_ONE    = WIDTH'(1);
    localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] idx;
    logic [WIDTH-1:0] idx_nxt;
    logic [WIDTH-1:0] idx_first;
    logic             dir_q;
    logic [7:0]       dwell;
    logic             hold_end;
    logic             last_idx;

    // Index-to-pattern mapping: binary by default, Gray code when enabled.
    function automatic logic [WIDTH-1:0] map_idx(input logic [WIDTH-1:0] i);
`ifdef SEQ_GRAY_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    // Termination is on the sweep index, never on counter overflow.
    assign hold_end  = (dwell == DWELL_LAST);
    assign last_idx  = dir_q ? (idx == '0) : (idx == IDX_MAX);
    assign idx_nxt   = dir_q ? (idx - IDX_ONE) : (idx + IDX_ONE);
    assign idx_first = dir ? IDX_MAX : '0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and status outputs; start is only honoured in IDLE.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (hold_end && last_idx) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sweep datapath: index/pattern stepping, dwell timing and response capture.
    // table_valid rises at the final capture so it is already high in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            pattern     <= '0;
            dir_q       <= 1'b0;
            dwell       <= '0;
            truth_table <= '0;
            table_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    truth_table <= '0;
                    table_valid <= 1'b0;
                    dir_q       <= dir;
                    idx         <= idx_first;
                    pattern     <= map_idx(idx_first);
                    dwell       <= '0;
                end
                RUN: begin
                    if (hold_end) begin
                        truth_table[pattern] <= y;
                        if (last_idx) begin
                            table_valid <= 1'b1;
                        end else begin
                            idx     <= idx_nxt;
                            pattern <= map_idx(idx_nxt);
                            dwell   <= '0;
                        end
                    end else begin
                        dwell <= dwell + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stim_sequencer.sv
// tb_stim_sequencer: randomized and directed sweeps of stim_sequencer (WIDTH=3,
// DWELL=4) against a truth-table/sequence model, with a decoupled scoreboard.
// Build with SEQ_GRAY_EN defined to check the Gray-code ordering.
module tb_stim_sequencer;

    localparam int WIDTH = 3;
    localparam int DWELL = 4;
    localparam int N     = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             dir = 1'b0;
    logic             y;
    logic [WIDTH-1:0] pattern;
    logic             busy;
    logic             done;
    logic [N-1:0]     truth_table;
    logic             table_valid;

    int           n_chk = 0;
    int           n_fail = 0;
    int           mode = 0;   // 0 AND3, 1 XOR3, 2 pattern[1], 3 capture-instant, 4 random table
    logic [N-1:0] rnd_tbl = '0;
    int           bcnt = 0;   // cycles spent busy in the current sweep

    logic [WIDTH-1:0] pat_q[$];
    logic [N-1:0]     tbl_q[$];

    always #5 clk = ~clk;

    stim_sequencer #(.WIDTH(WIDTH), .DWELL(DWELL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .y(y),
        .pattern(pattern), .busy(busy), .done(done),
        .truth_table(truth_table), .table_valid(table_valid)
    );

    always @(posedge clk) bcnt <= busy ? bcnt + 1 : 0;

    // Combinational stand-in for the DUT under test.
    always_comb begin
        case (mode)
            0:       y = &pattern;
            1:       y = ^pattern;
            2:       y = pattern[1];
            3:       y = ((bcnt % DWELL) == DWELL - 1) ? pattern[0] : (bcnt[0] ^ ~pattern[0]);
            default: y = rnd_tbl[pattern];
        endcase
    end

    function automatic logic exp_y(input int m, input logic [WIDTH-1:0] k, input logic [N-1:0] t);
        case (m)
            0:       return &k;
            1:       return ^k;
            2:       return k[1];
            3:       return k[0];
            default: return t[k];
        endcase
    endfunction

    function automatic logic [N-1:0] exp_table(input int m, input logic [N-1:0] t);
        logic [N-1:0] r = '0;
        for (int k = 0; k < N; k++) r[k] = exp_y(m, WIDTH'(k), t);
        return r;
    endfunction

    // s-th pattern of a sweep.
    function automatic logic [WIDTH-1:0] exp_pat(input int s, input logic d);
        int i = d ? (N - 1 - s) : s;
`ifdef SEQ_GRAY_EN
        i = i ^ (i >> 1);
`endif
        return WIDTH'(i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every busy cycle checks the presented pattern and its hold,
    // every done pulse checks sweep length and the captured table.
    initial begin
        logic [WIDTH-1:0] held = '0;
        int run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run = 0;
                continue;
            end
            if (busy) begin
                chk("tv_low_busy", {31'd0, table_valid}, 32'd0);
                if (run % DWELL == 0) begin
                    if (pat_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL pat_queue: got pattern %0d with no expected entry", pattern);
                    end else begin
                        held = pat_q.pop_front();
                        chk("pattern", {29'd0, pattern}, {29'd0, held});
                    end
                end else begin
                    chk("hold", {29'd0, pattern}, {29'd0, held});
                end
                run++;
            end
            if (done) begin
                chk("busy_len", run, N * DWELL);
                chk("tv_at_done", {31'd0, table_valid}, 32'd1);
                if (tbl_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL tbl_queue: got table %0h with no expected entry", truth_table);
                end else begin
                    chk("truth_table", {24'd0, truth_table}, {24'd0, tbl_q.pop_front()});
                end
                run = 0;
            end
        end
    end

    logic [WIDTH-1:0] last_pat;
    time t_start;

    task automatic issue(input logic d, input int m);
        @(negedge clk);
        mode = m;
        dir = d;
        start = 1'b1;
        t_start = $time;
        for (int s = 0; s < N; s++) pat_q.push_back(exp_pat(s, d));
        tbl_q.push_back(exp_table(m, rnd_tbl));
        last_pat = exp_pat(N - 1, d);
        @(negedge clk);
        start = 1'b0;
        dir = ~d;   // must not affect the running sweep
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL done_timeout: got no done expected done within 200 cycles");
        end else begin
            chk("done_latency", 32'((($time - t_start) / 10)), 32'd33);
            @(negedge clk);
            chk("done_pulse", {31'd0, done}, 32'd0);
            chk("tv_hold", {31'd0, table_valid}, 32'd1);
            chk("busy_idle", {31'd0, busy}, 32'd0);
            chk("pat_hold", {29'd0, pattern}, {29'd0, last_pat});
        end
    endtask

    task automatic wait_pat(input logic [WIDTH-1:0] p);
        int t = 0;
        while (pattern != p && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("wait_pat", {29'd0, pattern}, {29'd0, p});
    endtask

    task automatic check_zero(input string name);
        chk(name, {20'd0, pattern, busy, done, truth_table, table_valid}, 32'd0);
    endtask

    initial begin
        #1;
        check_zero("reset_state");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("idle_state");

        issue(1'b0, 0); wait_done();   // ascending AND3 -> 8'b1000_0000
        issue(1'b1, 1); wait_done();   // descending XOR3 -> 8'b1001_0110
        issue(1'b0, 3); wait_done();   // capture instant -> 8'b1010_1010
        issue(1'b0, 2); wait_done();   // y = pattern[1] -> 8'b1100_1100

        // start while busy is ignored
        issue(1'b0, 1);
        wait_pat(exp_pat(3, 1'b0));
        start = 1'b1; dir = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // reset mid-sweep
        issue(1'b0, 0);
        wait_pat(exp_pat(4, 1'b0));
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid");
        pat_q.delete();
        tbl_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("after_reset");
        issue(1'b0, 1); wait_done();

        // randomized truth functions and directions
        for (int r = 0; r < 6; r++) begin
            rnd_tbl = N'($urandom);
            issue(1'($urandom_range(0, 1)), 4);
            wait_done();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        chk("queues_empty", pat_q.size() + tbl_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
